rot_seq: RTL and testbench

- Tile sequencer that sits directly upstream of the DMA controller and drives its command and pixel-buffer address inputs.
- Rotates an 8-bit-per-pixel image of WIDTH x HEIGHT pixels by 90 degrees (clockwise or counter-clockwise) in 4x4-pixel tiles.
- Per tile: 4 single-word AHB reads (one per source row) fill the input buffer in transposed order; then 4 single-word writes (one per destination row) drain the output buffer.
- Raster tile order: tx fastest, then ty.

---
 rtl/rot_pkg.sv | 18 +
 rtl/rot_addr_gen.sv | 49 ++++
 rtl/rot_seq.sv | 214 +++++++++++++++++++++
 tb/tb_rot_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the 90-degree tile rotation sequencer.
package rot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [4:0] COUNT_ONE = 5'd1;
  localparam int         TILE      = 4;

endpackage

// File: rtl/rot_addr_gen.sv
// Combinational address and buffer-slot generator for the current tile row/column.
module rot_addr_gen
  import rot_pkg::*;
#(
  parameter int DIM_W  = 12,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] rd_row_i,
  input  logic [ADDR_W-1:0] wr_row_i,
  input  logic [DIM_W-1:0]  h_i,
  input  logic [DIM_W-3:0]  tx_i,
  input  logic [DIM_W-3:0]  ty_i,
  input  logic [1:0]        r_i,
  input  logic              ccw_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       in_slots_o,
  output logic [31:0]       out_slots_o
);

  localparam logic [ADDR_W-1:0] TILE_A = ADDR_W'(TILE);

  logic [ADDR_W-1:0] tx4_s;
  logic [ADDR_W-1:0] ty4_s;
  logic [ADDR_W-1:0] h_s;

  assign tx4_s = {{(ADDR_W-DIM_W){1'b0}}, tx_i, 2'b00};
  assign ty4_s = {{(ADDR_W-DIM_W){1'b0}}, ty_i, 2'b00};
  assign h_s   = {{(ADDR_W-DIM_W){1'b0}}, h_i};

  assign rd_addr_o = rd_row_i + tx4_s;
  // Clockwise tiles land mirrored vertically in the destination column band.
  assign wr_addr_o = wr_row_i + (ccw_i ? ty4_s : (h_s - TILE_A - ty4_s));

  // Transposed input slots per lane; output buffer is drained in order
  always_comb begin
    in_slots_o  = 32'h0000_0000;
    out_slots_o = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      if (ccw_i) begin
        in_slots_o[b*8 +: 8] = {4'h0, ~2'(b), r_i};
      end else begin
        in_slots_o[b*8 +: 8] = {4'h0, 2'(b), ~r_i};
      end
      out_slots_o[b*8 +: 8] = {4'h0, r_i, 2'(b)};
    end
  end

endmodule

// File: rtl/rot_seq.sv
// Tile sequencer driving a single-word DMA to rotate an 8bpp image by 90 degrees
// in 4x4 tiles; row products are tracked with incrementally updated base registers.
module rot_seq
  import rot_pkg::*;
#(
  parameter int DIM_W  = 12,
  parameter int ADDR_W = 32
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET,
  input  logic              I_GO,
  input  logic [ADDR_W-1:0] I_SRC_ADDR,
  input  logic [ADDR_W-1:0] I_DST_ADDR,
  input  logic [DIM_W-1:0]  I_WIDTH,
  input  logic [DIM_W-1:0]  I_HEIGHT,
  input  logic              I_CCW,
  input  logic              I_DMA_READY,
  output logic              O_START,
  output logic [ADDR_W-1:0] O_ADDR,
  output logic [2:0]        O_SIZE,
  output logic [4:0]        O_COUNT,
  output logic              O_WRITE,
  output logic [7:0]        O_PIXEL_IN_ADDR0,
  output logic [7:0]        O_PIXEL_IN_ADDR1,
  output logic [7:0]        O_PIXEL_IN_ADDR2,
  output logic [7:0]        O_PIXEL_IN_ADDR3,
  output logic [7:0]        O_PIXEL_OUT_ADDR0,
  output logic [7:0]        O_PIXEL_OUT_ADDR1,
  output logic [7:0]        O_PIXEL_OUT_ADDR2,
  output logic [7:0]        O_PIXEL_OUT_ADDR3,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR
);

  localparam int              TX_W   = DIM_W - 2;
  localparam logic [TX_W-1:0] TX_ONE = {{(TX_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic              ccw_q, ccw_d;
  logic [TX_W-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic [1:0]        r_q, r_d;
  logic              seen_low_q, seen_low_d;
  logic [ADDR_W-1:0] rd_tile_q, rd_tile_d, rd_row_q, rd_row_d;
  logic [ADDR_W-1:0] wr_col0_q, wr_col0_d, wr_tile_q, wr_tile_d, wr_row_q, wr_row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q, start_d, write_q, write_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]       pin_q, pin_d, pout_q, pout_d;

  logic [ADDR_W-1:0]  rd_addr_s, wr_addr_s, w_ext_s, h_ext_s, w4_s, h4_s, col0_s;
  logic [31:0]        in_slots_s, out_slots_s;
  logic [2*DIM_W-1:0] ccw_off_s;
  logic               dims_ok_s, tx_last_s, ty_last_s;

  assign w_ext_s = {{(ADDR_W-DIM_W){1'b0}}, w_q};
  assign h_ext_s = {{(ADDR_W-DIM_W){1'b0}}, h_q};
  assign w4_s    = {{(ADDR_W-DIM_W-2){1'b0}}, w_q, 2'b00};
  assign h4_s    = {{(ADDR_W-DIM_W-2){1'b0}}, h_q, 2'b00};

  assign dims_ok_s = (I_WIDTH != {DIM_W{1'b0}}) && (I_WIDTH[1:0] == 2'b00) &&
                     (I_HEIGHT != {DIM_W{1'b0}}) && (I_HEIGHT[1:0] == 2'b00);
  // One-off start column for CCW; the per-row walk itself uses adders only.
  assign ccw_off_s = {{DIM_W{1'b0}}, I_WIDTH - DIM_W'(TILE)} * {{DIM_W{1'b0}}, I_HEIGHT};
  assign col0_s    = I_CCW ? (I_DST_ADDR + {{(ADDR_W-2*DIM_W){1'b0}}, ccw_off_s}) : I_DST_ADDR;
  assign tx_last_s = (tx_q == (w_q[DIM_W-1:2] - TX_ONE));
  assign ty_last_s = (ty_q == (h_q[DIM_W-1:2] - TX_ONE));

  rot_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr_gen (
    .rd_row_i   (rd_row_q),
    .wr_row_i   (wr_row_q),
    .h_i        (h_q),
    .tx_i       (tx_q),
    .ty_i       (ty_q),
    .r_i        (r_q),
    .ccw_i      (ccw_q),
    .rd_addr_o  (rd_addr_s),
    .wr_addr_o  (wr_addr_s),
    .in_slots_o (in_slots_s),
    .out_slots_o(out_slots_s)
  );

  // Next-state, counter and output-register logic
  always_comb begin
    state_d = state_q;     w_d = w_q;           h_d = h_q;           ccw_d = ccw_q;
    tx_d = tx_q;           ty_d = ty_q;         r_d = r_q;           seen_low_d = seen_low_q;
    rd_tile_d = rd_tile_q; rd_row_d = rd_row_q; wr_col0_d = wr_col0_q;
    wr_tile_d = wr_tile_q; wr_row_d = wr_row_q; addr_d = addr_q;     write_d = write_q;
    pin_d = pin_q;         pout_d = pout_q;     busy_d = busy_q;
    start_d = 1'b0;        done_d = 1'b0;       err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_GO && dims_ok_s) begin
          w_d = I_WIDTH;      h_d = I_HEIGHT;     ccw_d = I_CCW;
          tx_d = {TX_W{1'b0}}; ty_d = {TX_W{1'b0}}; r_d = 2'd0;
          rd_tile_d = I_SRC_ADDR; rd_row_d = I_SRC_ADDR;
          wr_col0_d = col0_s;     wr_tile_d = col0_s;
          busy_d  = 1'b1;
          state_d = ST_RD_REQ;
        end else if (I_GO) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (I_DMA_READY) begin
          start_d = 1'b1; write_d = 1'b0; addr_d = rd_addr_s; pin_d = in_slots_s;
          seen_low_d = 1'b0;
          state_d = ST_RD_WAIT;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (!I_DMA_READY) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          seen_low_d = 1'b0;
          if (r_q == 2'd3) begin
            r_d = 2'd0; wr_row_d = wr_tile_q; state_d = ST_WR_REQ;
          end else begin
            r_d = r_q + 2'd1; rd_row_d = rd_row_q + w_ext_s; state_d = ST_RD_REQ;
          end
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (I_DMA_READY) begin
          start_d = 1'b1; write_d = 1'b1; addr_d = wr_addr_s; pout_d = out_slots_s;
          seen_low_d = 1'b0;
          state_d = ST_WR_WAIT;
        end else begin
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_WAIT: begin
        if (!I_DMA_READY) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          seen_low_d = 1'b0;
          if (r_q == 2'd3) begin
            r_d = 2'd0; state_d = ST_NEXT;
          end else begin
            r_d = r_q + 2'd1; wr_row_d = wr_row_q + h_ext_s; state_d = ST_WR_REQ;
          end
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_NEXT: begin
        if (tx_last_s) begin
          tx_d = {TX_W{1'b0}}; ty_d = ty_q + TX_ONE;
          rd_tile_d = rd_tile_q + w4_s; rd_row_d = rd_tile_q + w4_s;
          wr_tile_d = wr_col0_q;
          if (ty_last_s) begin
            busy_d = 1'b0; done_d = 1'b1; state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else begin
          tx_d = tx_q + TX_ONE; rd_row_d = rd_tile_q;
          wr_tile_d = ccw_q ? (wr_tile_q - h4_s) : (wr_tile_q + h4_s);
          state_d = ST_RD_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge I_HCLK or posedge I_HRESET) begin
    if (I_HRESET) begin
      state_q <= ST_IDLE;  w_q <= {DIM_W{1'b0}}; h_q <= {DIM_W{1'b0}}; ccw_q <= 1'b0;
      tx_q <= {TX_W{1'b0}}; ty_q <= {TX_W{1'b0}}; r_q <= 2'd0; seen_low_q <= 1'b0;
      rd_tile_q <= {ADDR_W{1'b0}}; rd_row_q <= {ADDR_W{1'b0}}; wr_col0_q <= {ADDR_W{1'b0}};
      wr_tile_q <= {ADDR_W{1'b0}}; wr_row_q <= {ADDR_W{1'b0}}; addr_q <= {ADDR_W{1'b0}};
      start_q <= 1'b0; write_q <= 1'b0; pin_q <= 32'h0; pout_q <= 32'h0;
      busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  w_q <= w_d;   h_q <= h_d;   ccw_q <= ccw_d;
      tx_q <= tx_d;        ty_q <= ty_d; r_q <= r_d;   seen_low_q <= seen_low_d;
      rd_tile_q <= rd_tile_d; rd_row_q <= rd_row_d; wr_col0_q <= wr_col0_d;
      wr_tile_q <= wr_tile_d; wr_row_q <= wr_row_d; addr_q <= addr_d;
      start_q <= start_d; write_q <= write_d; pin_q <= pin_d; pout_q <= pout_d;
      busy_q <= busy_d;   done_q <= done_d;   err_q <= err_d;
    end
  end

  assign O_START = start_q;
  assign O_ADDR  = addr_q;
  assign O_SIZE  = SIZE_WORD;
  assign O_COUNT = COUNT_ONE;
  assign O_WRITE = write_q;
  assign O_BUSY  = busy_q;
  assign O_DONE  = done_q;
  assign O_ERR   = err_q;
  assign O_PIXEL_IN_ADDR0  = pin_q[7:0];
  assign O_PIXEL_IN_ADDR1  = pin_q[15:8];
  assign O_PIXEL_IN_ADDR2  = pin_q[23:16];
  assign O_PIXEL_IN_ADDR3  = pin_q[31:24];
  assign O_PIXEL_OUT_ADDR0 = pout_q[7:0];
  assign O_PIXEL_OUT_ADDR1 = pout_q[15:8];
  assign O_PIXEL_OUT_ADDR2 = pout_q[23:16];
  assign O_PIXEL_OUT_ADDR3 = pout_q[31:24];

endmodule

// File: tb/tb_rot_seq.sv
// Scoreboard bench for rot_seq: expected transfers are queued by the stimulus,
// a monitor pops them on every O_START; a DMA/buffer/memory model closes the loop.
module tb_rot_seq;

  logic        I_HCLK = 1'b0;
  logic        I_HRESET;
  logic        I_GO;
  logic [31:0] I_SRC_ADDR, I_DST_ADDR;
  logic [11:0] I_WIDTH, I_HEIGHT;
  logic        I_CCW;
  logic        I_DMA_READY;
  logic        O_START, O_WRITE, O_BUSY, O_DONE, O_ERR;
  logic [31:0] O_ADDR;
  logic [2:0]  O_SIZE;
  logic [4:0]  O_COUNT;
  logic [7:0]  O_PIXEL_IN_ADDR0, O_PIXEL_IN_ADDR1, O_PIXEL_IN_ADDR2, O_PIXEL_IN_ADDR3;
  logic [7:0]  O_PIXEL_OUT_ADDR0, O_PIXEL_OUT_ADDR1, O_PIXEL_OUT_ADDR2, O_PIXEL_OUT_ADDR3;

  rot_seq dut (
    .I_HCLK(I_HCLK), .I_HRESET(I_HRESET), .I_GO(I_GO),
    .I_SRC_ADDR(I_SRC_ADDR), .I_DST_ADDR(I_DST_ADDR),
    .I_WIDTH(I_WIDTH), .I_HEIGHT(I_HEIGHT), .I_CCW(I_CCW), .I_DMA_READY(I_DMA_READY),
    .O_START(O_START), .O_ADDR(O_ADDR), .O_SIZE(O_SIZE), .O_COUNT(O_COUNT), .O_WRITE(O_WRITE),
    .O_PIXEL_IN_ADDR0(O_PIXEL_IN_ADDR0), .O_PIXEL_IN_ADDR1(O_PIXEL_IN_ADDR1),
    .O_PIXEL_IN_ADDR2(O_PIXEL_IN_ADDR2), .O_PIXEL_IN_ADDR3(O_PIXEL_IN_ADDR3),
    .O_PIXEL_OUT_ADDR0(O_PIXEL_OUT_ADDR0), .O_PIXEL_OUT_ADDR1(O_PIXEL_OUT_ADDR1),
    .O_PIXEL_OUT_ADDR2(O_PIXEL_OUT_ADDR2), .O_PIXEL_OUT_ADDR3(O_PIXEL_OUT_ADDR3),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR)
  );

  always #5 I_HCLK = ~I_HCLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic        chk;
    logic [31:0] slots;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          n_start = 0, n_done = 0, n_err = 0;
  logic        dma_rdy, hold_low;
  logic [7:0]  pbuf [16];
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] in_slots_w, out_slots_w;

  assign I_DMA_READY = dma_rdy & ~hold_low;
  assign in_slots_w  = {O_PIXEL_IN_ADDR3, O_PIXEL_IN_ADDR2, O_PIXEL_IN_ADDR1, O_PIXEL_IN_ADDR0};
  assign out_slots_w = {O_PIXEL_OUT_ADDR3, O_PIXEL_OUT_ADDR2, O_PIXEL_OUT_ADDR1, O_PIXEL_OUT_ADDR0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic chk, input logic [31:0] slots);
    exp_t e;
    e.wr = wr; e.addr = addr; e.chk = chk; e.slots = slots;
    exp_q.push_back(e);
  endtask

  // 4x4 CW at SRC=0x1000, DST=0x2000, including every slot pattern
  task automatic push_t1();
    push(1'b0, 32'h1000, 1'b1, 32'h0F0B0703);
    push(1'b0, 32'h1004, 1'b1, 32'h0E0A0602);
    push(1'b0, 32'h1008, 1'b1, 32'h0D090501);
    push(1'b0, 32'h100C, 1'b1, 32'h0C080400);
    push(1'b1, 32'h2000, 1'b1, 32'h03020100);
    push(1'b1, 32'h2004, 1'b1, 32'h07060504);
    push(1'b1, 32'h2008, 1'b1, 32'h0B0A0908);
    push(1'b1, 32'h200C, 1'b1, 32'h0F0E0D0C);
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [11:0] w,
                    input logic [11:0] h, input logic ccw);
    @(negedge I_HCLK);
    I_SRC_ADDR = s; I_DST_ADDR = d; I_WIDTH = w; I_HEIGHT = h; I_CCW = ccw; I_GO = 1'b1;
    @(negedge I_HCLK);
    I_GO = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge I_HCLK);
      k++;
    end
    check(name, (n_done > d0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " start"}, O_START, 32'd0);
    check({tag, " addr"}, O_ADDR, 32'd0);
    check({tag, " write"}, O_WRITE, 32'd0);
    check({tag, " busy"}, O_BUSY, 32'd0);
    check({tag, " done"}, O_DONE, 32'd0);
    check({tag, " err"}, O_ERR, 32'd0);
    check({tag, " size"}, O_SIZE, 32'd2);
    check({tag, " count"}, O_COUNT, 32'd1);
    check({tag, " in slots"}, in_slots_w, 32'd0);
    check({tag, " out slots"}, out_slots_w, 32'd0);
  endtask

  // Monitor: pop the scoreboard on every transfer request, count DONE/ERR pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge I_HCLK);
      if (!I_HRESET) begin
        if (O_START) begin
          n_start++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected start: addr %h write %0d, nothing expected", O_ADDR, O_WRITE);
          end else begin
            e = exp_q.pop_front();
            check("start addr", O_ADDR, e.addr);
            check("start write", {31'd0, O_WRITE}, {31'd0, e.wr});
            check("start size", {29'd0, O_SIZE}, 32'd2);
            if (e.chk) check("start slots", e.wr ? out_slots_w : in_slots_w, e.slots);
          end
        end
        if (O_DONE) begin
          n_done++;
          check("busy low at done", {31'd0, O_BUSY}, 32'd0);
        end
        if (O_ERR) n_err++;
      end
    end
  end

  // DMA + buffer model: moves the word, drops READY 2 cycles after START, raises it 3 later
  initial begin
    dma_rdy = 1'b1;
    forever begin
      @(negedge I_HCLK);
      if (O_START && !I_HRESET) begin
        for (int b = 0; b < 4; b++) begin
          if (!O_WRITE) pbuf[in_slots_w[b*8 +: 4]] = mem.exists(O_ADDR + 32'(b)) ? mem[O_ADDR + 32'(b)] : 8'h00;
          else mem[O_ADDR + 32'(b)] = pbuf[out_slots_w[b*8 +: 4]];
        end
        repeat (2) @(negedge I_HCLK);
        dma_rdy = 1'b0;
        repeat (3) @(negedge I_HCLK);
        dma_rdy = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, k;
    I_HRESET = 1'b1; I_GO = 1'b0; hold_low = 1'b0; I_CCW = 1'b0;
    I_SRC_ADDR = 32'h0; I_DST_ADDR = 32'h0; I_WIDTH = 12'd0; I_HEIGHT = 12'd0;
    repeat (3) @(negedge I_HCLK);
    check_reset_outputs("reset");
    I_HRESET = 1'b0;
    @(negedge I_HCLK);

    // 4x4 clockwise
    s0 = n_start;
    push_t1();
    go(32'h1000, 32'h2000, 12'd4, 12'd4, 1'b0);
    check("t1 busy after go", {31'd0, O_BUSY}, 32'd1);
    wait_done("t1 done", 400);
    check("t1 start count", 32'(n_start - s0), 32'd8);
    check("t1 queue drained", 32'(exp_q.size()), 32'd0);
    @(negedge I_HCLK);
    check("t1 done is a pulse", {31'd0, O_DONE}, 32'd0);

    // Reset while in WR_WAIT of the first write, then restart cleanly
    s0 = n_start;
    push_t1();
    go(32'h1000, 32'h2000, 12'd4, 12'd4, 1'b0);
    k = 0;
    while (n_start < s0 + 5 && k < 300) begin
      @(negedge I_HCLK);
      k++;
    end
    check("reach wr_wait", (n_start >= s0 + 5) ? 32'd1 : 32'd0, 32'd1);
    @(negedge I_HCLK);
    #2 I_HRESET = 1'b1;
    #1 check_reset_outputs("mid reset");
    exp_q.delete();
    @(negedge I_HCLK);
    I_HRESET = 1'b0;
    s0 = n_start;
    repeat (20) @(negedge I_HCLK);
    check("no start after reset", 32'(n_start - s0), 32'd0);
    push_t1();
    go(32'h1000, 32'h2000, 12'd4, 12'd4, 1'b0);
    wait_done("restart done", 400);
    check("restart start count", 32'(n_start - s0), 32'd8);

    // 8x4 counter-clockwise
    s0 = n_start;
    push(1'b0, 32'h000, 1'b1, 32'h0004080C);
    push(1'b0, 32'h008, 1'b0, 32'h0); push(1'b0, 32'h010, 1'b0, 32'h0); push(1'b0, 32'h018, 1'b0, 32'h0);
    push(1'b1, 32'h110, 1'b0, 32'h0); push(1'b1, 32'h114, 1'b0, 32'h0);
    push(1'b1, 32'h118, 1'b0, 32'h0); push(1'b1, 32'h11C, 1'b0, 32'h0);
    push(1'b0, 32'h004, 1'b0, 32'h0); push(1'b0, 32'h00C, 1'b0, 32'h0);
    push(1'b0, 32'h014, 1'b0, 32'h0); push(1'b0, 32'h01C, 1'b0, 32'h0);
    push(1'b1, 32'h100, 1'b0, 32'h0); push(1'b1, 32'h104, 1'b0, 32'h0);
    push(1'b1, 32'h108, 1'b0, 32'h0); push(1'b1, 32'h10C, 1'b0, 32'h0);
    go(32'h0, 32'h100, 12'd8, 12'd4, 1'b1);
    wait_done("ccw done", 600);
    check("ccw start count", 32'(n_start - s0), 32'd16);

    // Rejected configurations
    s0 = n_start; e0 = n_err;
    go(32'h0, 32'h100, 12'd6, 12'd4, 1'b0);
    check("err width6 pulse", {31'd0, O_ERR}, 32'd1);
    check("err width6 busy", {31'd0, O_BUSY}, 32'd0);
    @(negedge I_HCLK);
    check("err is a pulse", {31'd0, O_ERR}, 32'd0);
    go(32'h0, 32'h100, 12'd4, 12'd0, 1'b0);
    check("err height0 pulse", {31'd0, O_ERR}, 32'd1);
    repeat (10) @(negedge I_HCLK);
    check("err count", 32'(n_err - e0), 32'd2);
    check("err no start", 32'(n_start - s0), 32'd0);
    check("err busy idle", {31'd0, O_BUSY}, 32'd0);

    // READY held low in RD_REQ; second GO while busy is ignored
    hold_low = 1'b1;
    s0 = n_start; e0 = n_err;
    push(1'b0, 32'h3000, 1'b0, 32'h0); push(1'b0, 32'h3004, 1'b0, 32'h0);
    push(1'b0, 32'h3008, 1'b0, 32'h0); push(1'b0, 32'h300C, 1'b0, 32'h0);
    push(1'b1, 32'h3100, 1'b0, 32'h0); push(1'b1, 32'h3104, 1'b0, 32'h0);
    push(1'b1, 32'h3108, 1'b0, 32'h0); push(1'b1, 32'h310C, 1'b0, 32'h0);
    go(32'h3000, 32'h3100, 12'd4, 12'd4, 1'b0);
    repeat (50) @(negedge I_HCLK);
    check("hold no start", 32'(n_start - s0), 32'd0);
    check("hold busy", {31'd0, O_BUSY}, 32'd1);
    go(32'h7000, 32'h7800, 12'd8, 12'd8, 1'b1);
    hold_low = 1'b0;
    wait_done("hold done", 400);
    check("hold start count", 32'(n_start - s0), 32'd8);
    check("ignored go no err", 32'(n_err - e0), 32'd0);

    // Golden 8x8 clockwise rotation through the DMA/buffer model
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        mem[32'h4000 + 32'(i * 8 + j)] = 8'(i * 13 + j * 7 + 5);
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 2; tx++) begin
        for (int r = 0; r < 4; r++)
          push(1'b0, 32'h4000 + 32'((ty * 4 + r) * 8 + tx * 4), 1'b0, 32'h0);
        for (int c = 0; c < 4; c++)
          push(1'b1, 32'h5000 + 32'((tx * 4 + c) * 8 + (4 - ty * 4)), 1'b0, 32'h0);
      end
    s0 = n_start;
    go(32'h4000, 32'h5000, 12'd8, 12'd8, 1'b0);
    wait_done("golden done", 1500);
    check("golden start count", 32'(n_start - s0), 32'd32);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        check("golden pixel",
              {24'd0, mem.exists(32'h5000 + 32'(i * 8 + j)) ? mem[32'h5000 + 32'(i * 8 + j)] : 8'hXX},
              {24'd0, 8'((7 - j) * 13 + i * 7 + 5)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
